// File: rtl/cdc_handshake_tx_if.sv
// Bundle between the handshake source block, its local producer and the destination domain.
// No latency of its own; wires only.
// The master modport is the source block. The slave modport is the local producer plus the destination.
interface cdc_handshake_tx_if #(
   parameter int DATA_W = 8
);
   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              ready_o;
   logic              done_o;
   logic              req_o;
   logic [DATA_W-1:0] data_o;
   logic              ack_i;
   logic              timeout_o;

   modport master (
      input  valid_i, data_i, ack_i,
      output ready_o, done_o, req_o, data_o, timeout_o
   );

   modport slave (
      output valid_i, data_i, ack_i,
      input  ready_o, done_o, req_o, data_o, timeout_o
   );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing. With ack looped back, a word takes 2*(SYNC_STAGES+1) cycles from accept to done_o.
// ready_o is low from accept until ack is seen low again, and also while a stale synchronized ack is high.
// Macro CDC_HANDSHAKE_TIMEOUT_EN aborts a REQ phase that gets no ack within TIMEOUT_CYC cycles.
module cdc_handshake_tx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   cdc_handshake_tx_if.master     bus
);

   typedef enum logic [1:0] {IDLE, REQ, ACK_LOW} state_t;

   state_t                  state_q, state_d;
   logic                    req_q, req_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    done_q, done_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    ack_s;
   logic                    ready;

   // Only the last synchronizer stage is used, so ack_i never reaches logic unsynchronized.
   assign ack_s = sync_q[SYNC_STAGES-1];
   assign ready = (state_q == IDLE) && !ack_s;

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tout_q, tout_d;
   logic             abort_q, abort_d;
`endif

   // Shift the asynchronous ack through the synchronizer chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_i};
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
         cnt_q   <= '0;
         tout_q  <= 1'b0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
         abort_q <= abort_d;
`endif
      end
   end

   // Next-state logic; data_q changes only on accept, so it stays frozen for the whole handshake.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
      cnt_d   = cnt_q;
      tout_d  = 1'b0;
      abort_d = abort_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.valid_i && ready) begin
               data_d  = bus.data_i;
               req_d   = 1'b1;
               state_d = REQ;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
               cnt_d   = '0;
               abort_d = 1'b0;
`endif
            end
         end
         REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ACK_LOW;
            end
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
            // The last REQ cycle is the one with cnt_q == TIMEOUT_CYC-1, so req_o is high for exactly TIMEOUT_CYC cycles.
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               req_d   = 1'b0;
               state_d = ACK_LOW;
               tout_d  = 1'b1;
               abort_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ACK_LOW: begin
            if (!ack_s) begin
               state_d = IDLE;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
               done_d  = !abort_q;
`else
               done_d  = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready_o = ready;
   assign bus.req_o   = req_q;
   assign bus.data_o  = data_q;
   assign bus.done_o  = done_q;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
   assign bus.timeout_o = tout_q;
`else
   assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic loop = 1'b0;
   logic ack_drv = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   cdc_handshake_tx_if #(.DATA_W(DW)) ifc ();

   assign ifc.ack_i = loop ? ifc.req_o : ack_drv;

   cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc.master)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle at the falling edge where checks and drives happen.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] words [4];
      logic       req_exp [7];
      logic       done_exp [7];
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
      req_exp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      done_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      ifc.valid_i = 1'b0;
      ifc.data_i  = '0;

      // Reset, then idle with ack low.
      @(negedge clk);
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rst_ready", ifc.ready_o, 1);
      chk("rst_req", ifc.req_o, 0);
      chk("rst_data", ifc.data_o, 0);
      chk("rst_done", ifc.done_o, 0);
      chk("rst_tout", ifc.timeout_o, 0);

      // Single loopback transfer of 0xA5.
      loop = 1'b1;
      ifc.valid_i = 1'b1;
      ifc.data_i  = 8'hA5;
      tick();
      ifc.valid_i = 1'b0;
      ifc.data_i  = 8'h00;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick();
         chk($sformatf("a5_req%0d", i), ifc.req_o, req_exp[i]);
         chk($sformatf("a5_done%0d", i), ifc.done_o, done_exp[i]);
         chk($sformatf("a5_ready%0d", i), ifc.ready_o, done_exp[i]);
         chk($sformatf("a5_data%0d", i), ifc.data_o, 8'hA5);
      end
      tick();
      chk("a5_done_end", ifc.done_o, 0);

      // Four back-to-back words with valid held high and data_i scrambled mid-transfer.
      ifc.valid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ifc.data_i = words[k];
         tick();
         chk($sformatf("b2b_req_w%0d", k), ifc.req_o, 1);
         ifc.data_i = 8'hFF;
         for (int c = 1; c < 6; c++) begin
            tick();
            chk($sformatf("b2b_data_w%0d_c%0d", k, c), ifc.data_o, words[k]);
            chk($sformatf("b2b_done_w%0d_c%0d", k, c), ifc.done_o, 0);
         end
         tick();
         chk($sformatf("b2b_done_w%0d", k), ifc.done_o, 1);
         chk($sformatf("b2b_ready_w%0d", k), ifc.ready_o, 1);
         chk($sformatf("b2b_hold_w%0d", k), ifc.data_o, words[k]);
      end
      ifc.valid_i = 1'b0;
      tick();
      chk("b2b_done_end", ifc.done_o, 0);

      // Reset during REQ while the destination holds ack high.
      loop = 1'b0;
      ack_drv = 1'b0;
      ifc.valid_i = 1'b1;
      ifc.data_i  = 8'h3C;
      tick();
      ifc.valid_i = 1'b0;
      chk("rr_req_before", ifc.req_o, 1);
      ack_drv = 1'b1;
      rst = 1'b1;
      tick();
      chk("rr_req_after", ifc.req_o, 0);
      chk("rr_data_after", ifc.data_o, 0);
      rst = 1'b0;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rr_ready%0d", i), ifc.ready_o, 0);
         chk($sformatf("rr_done%0d", i), ifc.done_o, 0);
         chk($sformatf("rr_req%0d", i), ifc.req_o, 0);
         tick();
      end
      ack_drv = 1'b0;
      tick();
      chk("rr_ready_sync", ifc.ready_o, 0);
      tick();
      chk("rr_ready_free", ifc.ready_o, 1);
      chk("rr_done_free", ifc.done_o, 0);

      // Destination holds ack high for 10 cycles.
      ifc.valid_i = 1'b1;
      ifc.data_i  = 8'h5A;
      tick();
      ifc.valid_i = 1'b0;
      ack_drv = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk($sformatf("hold_ready%0d", i), ifc.ready_o, 0);
         chk($sformatf("hold_done%0d", i), ifc.done_o, 0);
         chk($sformatf("hold_tout%0d", i), ifc.timeout_o, 0);
         if (i >= 3) chk($sformatf("hold_req%0d", i), ifc.req_o, 0);
      end
      ack_drv = 1'b0;
      tick();
      chk("hold_done_f1", ifc.done_o, 0);
      tick();
      chk("hold_done_f2", ifc.done_o, 0);
      tick();
      chk("hold_done_f3", ifc.done_o, 1);
      chk("hold_ready_f3", ifc.ready_o, 1);
      chk("hold_data_f3", ifc.data_o, 8'h5A);
      tick();

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
      // Ack stuck low: abort after 8 REQ cycles.
      ifc.valid_i = 1'b1;
      ifc.data_i  = 8'h77;
      tick();
      ifc.valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         chk($sformatf("to_req%0d", i), ifc.req_o, 1);
         chk($sformatf("to_tout%0d", i), ifc.timeout_o, 0);
      end
      tick();
      chk("to_req_drop", ifc.req_o, 0);
      chk("to_pulse", ifc.timeout_o, 1);
      chk("to_done", ifc.done_o, 0);
      tick();
      chk("to_pulse_end", ifc.timeout_o, 0);
      chk("to_done_end", ifc.done_o, 0);
      chk("to_ready", ifc.ready_o, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
